// File: rtl/if_id_fetch_stage_pkg.sv
// rtl/if_id_fetch_stage_pkg.sv - shared widths, instruction field layout and fetch FSM encoding
package if_id_fetch_stage_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS_HI   = 8;
    localparam int RS_LO   = 6;
    localparam int RT_HI   = 5;
    localparam int RT_LO   = 3;
    localparam int IMM3_HI = 2;
    localparam int IMM3_LO = 0;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// rtl/if_id_fetch_stage_if.sv - instruction memory req/ack handshake bundle
interface if_id_fetch_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_id_fetch_stage_instr_field_split.sv
// rtl/if_id_fetch_stage_instr_field_split.sv - splits a 16-bit instruction into decode fields
module instr_field_split
    import if_id_fetch_stage_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [2:0]  rd,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  imm3
);
    assign opcode = instr[OPC_HI:OPC_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign imm3   = instr[IMM3_HI:IMM3_LO];
endmodule

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - fetch FSM, PC, one-entry skid and IF/ID register
module if_id_fetch_stage #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    if_id_fetch_stage_if.master      imem,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     id_valid,
    output logic [PC_W-1:0]          id_pc,
    output logic [3:0]               id_opcode,
    output logic [2:0]               id_rd,
    output logic [2:0]               id_rs,
    output logic [2:0]               id_rt,
    output logic [2:0]               id_imm3
);
    import if_id_fetch_stage_pkg::*;

    logic [0:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;
    logic               slot_free;

    // A slot whose occupant is leaving this cycle can be refilled in the same cycle.
    assign slot_free = !id_valid_q || !stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        if (redirect) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            state_d    = ST_FETCH;
        end else if (state_q == ST_FETCH) begin
            if (imem.imem_ack) begin
                pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                if (slot_free) begin
                    id_instr_d = imem.imem_rdata;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                end else begin
                    skid_instr_d = imem.imem_rdata;
                    skid_pc_d    = pc_q;
                    state_d      = ST_HOLD;
                end
            end else if (slot_free) begin
                id_valid_d = 1'b0;
            end
        end else if (!stall) begin
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q;
            id_valid_d = 1'b1;
            state_d    = ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
        end
    end

    // Gated with rst so the request drops combinationally, not at the next edge.
    assign imem.imem_req  = (state_q == ST_FETCH) && !rst;
    assign imem.imem_addr = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;

    instr_field_split u_split (
        .instr  (id_instr_q),
        .opcode (id_opcode),
        .rd     (id_rd),
        .rs     (id_rs),
        .rt     (id_rt),
        .imm3   (id_imm3)
    );
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - directed and scoreboard bench for if_id_fetch_stage
module tb_if_id_fetch_stage;
    logic       clk;
    logic       rst;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       id_valid;
    logic [7:0] id_pc;
    logic [3:0] id_opcode;
    logic [2:0] id_rd, id_rs, id_rt, id_imm3;

    int checks   = 0;
    int failures = 0;

    if_id_fetch_stage_if #(.PC_W(8), .INSTR_W(16)) imem ();

    if_id_fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_opcode   (id_opcode),
        .id_rd       (id_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_imm3     (id_imm3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] id_word();
        return {id_opcode, id_rd, id_rs, id_rt, id_imm3};
    endfunction

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    logic [7:0] exp_pc;
    int         accepted;
    logic [7:0] sext;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        imem.imem_ack = 1'b0; imem.imem_rdata = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("pre_reset_req", imem.imem_req, 1);

        // 1: reset mid-fetch
        rst = 1'b1;
        #1;
        chk("rst_req_low", imem.imem_req, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_word", id_word(), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_addr", imem.imem_addr, 8'h00);
        chk("rel_req", imem.imem_req, 1);

        // 2: first fetch
        imem.imem_ack = 1'b1; imem.imem_rdata = 16'h1A5B;
        tick();
        chk("f1_valid", id_valid, 1);
        chk("f1_pc", id_pc, 8'h00);
        chk("f1_opc", id_opcode, 4'h1);
        chk("f1_rd", id_rd, 3'd5);
        chk("f1_rs", id_rs, 3'd1);
        chk("f1_rt", id_rt, 3'd3);
        chk("f1_imm3", id_imm3, 3'b011);
        chk("f1_addr", imem.imem_addr, 8'h01);

        // 3: stall into skid, then release
        stall = 1'b1; imem.imem_rdata = 16'h2C0D;
        tick();
        chk("st_req", imem.imem_req, 0);
        chk("st_pc", id_pc, 8'h00);
        chk("st_word", id_word(), 16'h1A5B);
        imem.imem_ack = 1'b0;
        tick();
        chk("st2_word", id_word(), 16'h1A5B);
        chk("st2_valid", id_valid, 1);
        stall = 1'b0;
        tick();
        chk("rel_valid", id_valid, 1);
        chk("rel_pc", id_pc, 8'h01);
        chk("rel_opc", id_opcode, 4'h2);
        chk("rel_rd", id_rd, 3'd6);
        chk("rel_rs", id_rs, 3'd0);
        chk("rel_rt", id_rt, 3'd1);
        chk("rel_imm3", id_imm3, 3'b101);
        sext = {{5{id_imm3[2]}}, id_imm3};
        chk("rel_sext", sext, 8'hFD);
        chk("rel_req_back", imem.imem_req, 1);
        chk("rel_addr2", imem.imem_addr, 8'h02);

        // 4: redirect with full skid and simultaneous ack
        stall = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 16'h3333;
        tick();
        chk("sk_full_req", imem.imem_req, 0);
        redirect = 1'b1; redirect_pc = 8'h40; imem.imem_rdata = 16'h4444;
        tick();
        chk("rd_valid", id_valid, 0);
        chk("rd_addr", imem.imem_addr, 8'h40);
        chk("rd_req", imem.imem_req, 1);
        redirect = 1'b0; imem.imem_ack = 1'b0; stall = 1'b0;
        tick();
        chk("rd_no_skid", id_valid, 0);
        imem.imem_ack = 1'b1; imem.imem_rdata = 16'h5555;
        tick();
        chk("rd_f_valid", id_valid, 1);
        chk("rd_f_pc", id_pc, 8'h40);
        chk("rd_f_word", id_word(), 16'h5555);
        chk("rd_f_addr", imem.imem_addr, 8'h41);

        // 5: PC wrap
        imem.imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0; imem.imem_ack = 1'b1; imem.imem_rdata = 16'hF123;
        tick();
        chk("wr_pc", id_pc, 8'hFF);
        chk("wr_opc", id_opcode, 4'hF);
        chk("wr_addr", imem.imem_addr, 8'h00);

        // 6: alternating ack, random stall, in-order scoreboard across the wrap
        imem.imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 8'hF0;
        tick();
        redirect = 1'b0;
        exp_pc = 8'hF0;
        accepted = 0;
        for (int c = 0; c < 200; c++) begin
            stall = 1'($urandom_range(0, 1));
            imem.imem_ack = imem.imem_req && c[0];
            imem.imem_rdata = mem_word(imem.imem_addr);
            if (id_valid && !stall) begin
                chk("sb_pc", id_pc, exp_pc);
                chk("sb_word", id_word(), mem_word(exp_pc));
                exp_pc = exp_pc + 8'h01;
                accepted++;
            end
            tick();
        end
        chk("sb_progress", (accepted >= 30) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
